// File: rtl/fetch_pkg.sv
// Shared types and constants for the pc_fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;

endpackage

// File: rtl/pc_fetch.sv
// Fetch stage: holds the architectural PC, issues one imem read per PC and hands {instr, pc} to decode.
// Optional FETCH_MISALIGN_TRAP_EN: adds fetch_misalign_o and stalls in REQ on a misaligned PC until flush.
//
// state | meaning
// IDLE  | one cycle after reset release, no request yet
// REQ   | request pc_q to imem, waiting for grant
// WAIT  | granted, waiting for rvalid (dropped if kill_q)
// OUT   | instruction held for decode until handshake or flush
module pc_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(DEFAULT_RESET_VECTOR)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] next_pc_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic                  fetch_misalign_o,
`endif
  output logic [DATA_WIDTH-1:0] pc_o
);

  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pcout_q, pcout_d;
  logic                  kill_q, kill_d;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned       = (pc_q[1:0] != 2'b00);
  assign imem_req_o       = (state_q == REQ) && !misaligned;
  assign fetch_misalign_o = (state_q == REQ) && misaligned;
`else
  assign imem_req_o       = (state_q == REQ);
`endif

  assign imem_addr_o   = pc_q;
  assign pc_plus4_o    = pc_q + DATA_WIDTH'(4);
  assign instr_valid_o = (state_q == OUT);
  assign instr_o       = instr_q;
  assign pc_o          = pcout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      kill_q  <= 1'b0;
      instr_q <= DATA_WIDTH'(NOP_INSTR);
      pcout_q <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      instr_q <= instr_d;
      pcout_q <= pcout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    instr_d = instr_q;
    pcout_d = pcout_q;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // a grant in a flush cycle is still outstanding, so its data must be dropped
        if (imem_req_o && imem_gnt_i) begin
          state_d = WAIT;
          kill_d  = flush_i;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          if (!kill_q && !flush_i) begin
            instr_d = imem_rdata_i;
            pcout_d = pc_q;
            state_d = OUT;
          end else begin
            state_d = REQ;
          end
          kill_d = 1'b0;
        end else if (flush_i) begin
          kill_d = 1'b1;
        end
      end
      OUT: begin
        if (flush_i) begin
          state_d = REQ;
        end else if (instr_ready_i) begin
          state_d = REQ;
          pc_d    = next_pc_i;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) pc_d = next_pc_i;

`ifndef FETCH_MISALIGN_TRAP_EN
    pc_d[1:0] = 2'b00;
`endif
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch with a transaction-level reference model checked every cycle.
module tb_pc_fetch;

  localparam logic [31:0] RV  = 32'hBFC0_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] next_pc_i;
  logic        flush_i;
  logic [31:0] pc_plus4_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .next_pc_i     (next_pc_i),
    .flush_i       (flush_i),
    .pc_plus4_o    (pc_plus4_o),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
`ifdef FETCH_MISALIGN_TRAP_EN
    .fetch_misalign_o (fetch_misalign_o),
`endif
    .pc_o          (pc_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fetch viewed as outstanding-read bookkeeping plus a held instruction.
  logic        m_ok = 1'b0;
  logic        m_started, m_pending, m_stale, m_hold;
  logic [31:0] m_pc, m_instr, m_pco;
  logic        exp_req, exp_trap, m_fetching;

  function automatic logic [31:0] load_pc(input logic [31:0] v);
`ifdef FETCH_MISALIGN_TRAP_EN
    return v;
`else
    return {v[31:2], 2'b00};
`endif
  endfunction

  assign m_fetching = m_started && !m_pending && !m_hold;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign exp_req  = m_fetching && (m_pc[1:0] == 2'b00);
  assign exp_trap = m_fetching && (m_pc[1:0] != 2'b00);
`else
  assign exp_req  = m_fetching;
  assign exp_trap = 1'b0;
`endif

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ok      <= 1'b1;
      m_started <= 1'b0;
      m_pending <= 1'b0;
      m_stale   <= 1'b0;
      m_hold    <= 1'b0;
      m_pc      <= RV;
      m_instr   <= NOP;
      m_pco     <= RV;
    end else begin
      m_started <= 1'b1;
      if (exp_req && imem_gnt_i) begin
        m_pending <= 1'b1;
        m_stale   <= flush_i;
      end else if (m_pending && imem_rvalid_i) begin
        m_pending <= 1'b0;
        m_stale   <= 1'b0;
        if (!m_stale && !flush_i) begin
          m_hold  <= 1'b1;
          m_instr <= imem_rdata_i;
          m_pco   <= m_pc;
        end
      end else if (m_pending && flush_i) begin
        m_stale <= 1'b1;
      end
      if (m_hold && (flush_i || instr_ready_i)) m_hold <= 1'b0;
      if (flush_i || (m_hold && instr_ready_i)) m_pc <= load_pc(next_pc_i);
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("cmp_req", 32'(imem_req_o), 32'(exp_req));
      check("cmp_valid", 32'(instr_valid_o), 32'(m_hold));
      check("cmp_instr", instr_o, m_instr);
      check("cmp_pc_o", pc_o, m_pco);
      check("cmp_pc_plus4", pc_plus4_o, m_pc + 32'd4);
      if (exp_req) check("cmp_addr", imem_addr_o, m_pc);
`ifdef FETCH_MISALIGN_TRAP_EN
      check("cmp_trap", 32'(fetch_misalign_o), 32'(exp_trap));
`endif
    end
  end

  task automatic step(input logic g, input logic rv, input logic [31:0] rd,
                      input logic rdy, input logic fl, input logic [31:0] npc);
    imem_gnt_i    = g;
    imem_rvalid_i = rv;
    imem_rdata_i  = rd;
    instr_ready_i = rdy;
    flush_i       = fl;
    next_pc_i     = npc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_instr", instr_o, 32'h0000_0013);
    check("rst_pc_o", pc_o, 32'hBFC0_0000);
    check("rst_pc_plus4", pc_plus4_o, 32'hBFC0_0004);

    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    check("first_req", 32'(imem_req_o), 32'd1);
    check("first_addr", imem_addr_o, 32'hBFC0_0000);
    step(1, 0, 0, 0, 0, 0);
    check("wait_no_req", 32'(imem_req_o), 32'd0);
    step(0, 1, 32'h0050_0093, 0, 0, 0);
    check("first_valid", 32'(instr_valid_o), 32'd1);
    check("first_instr", instr_o, 32'h0050_0093);
    check("first_pc_o", pc_o, 32'hBFC0_0000);

    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 32'hBFC0_0004);
      check("stall_valid", 32'(instr_valid_o), 32'd1);
      check("stall_instr", instr_o, 32'h0050_0093);
      check("stall_no_req", 32'(imem_req_o), 32'd0);
    end
    step(0, 0, 0, 1, 0, 32'hBFC0_0004);
    check("hs_valid_drop", 32'(instr_valid_o), 32'd0);
    check("hs_next_addr", imem_addr_o, 32'hBFC0_0004);

    // flush while waiting: stale data must never reach decode
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'hBFC0_0100);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    check("stale_no_valid", 32'(instr_valid_o), 32'd0);
    check("stale_instr_kept", instr_o, 32'h0050_0093);
    check("flush_addr", imem_addr_o, 32'hBFC0_0100);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h00A0_0113, 0, 0, 0);
    check("slow_rvalid_instr", instr_o, 32'h00A0_0113);
    check("slow_rvalid_pc_o", pc_o, 32'hBFC0_0100);

    // flush and ready together in OUT
    step(0, 0, 0, 1, 1, 32'hBFC0_0200);
    check("fl_rdy_valid", 32'(instr_valid_o), 32'd0);
    check("fl_rdy_addr", imem_addr_o, 32'hBFC0_0200);

    // flush in REQ with a grant in the same cycle
    step(1, 0, 0, 0, 1, 32'hBFC0_0300);
    step(0, 1, 32'h1111_1111, 0, 0, 0);
    check("fl_gnt_valid", 32'(instr_valid_o), 32'd0);
    check("fl_gnt_addr", imem_addr_o, 32'hBFC0_0300);

    step(0, 0, 0, 0, 1, 32'hBFC0_0400);
    check("fl_req_addr", imem_addr_o, 32'hBFC0_0400);

    // flush in WAIT coinciding with rvalid
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h2222_2222, 0, 1, 32'hBFC0_0500);
    check("fl_rv_valid", 32'(instr_valid_o), 32'd0);
    check("fl_rv_addr", imem_addr_o, 32'hBFC0_0500);

    // PC wrap at the top of the address space
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h3333_3333, 0, 0, 0);
    check("pre_wrap_pc_o", pc_o, 32'hBFC0_0500);
    step(0, 0, 0, 1, 0, 32'hFFFF_FFFC);
    check("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4_o, 32'h0000_0000);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h6666_6666, 0, 0, 0);
    check("wrap_pc_o", pc_o, 32'hFFFF_FFFC);
    step(0, 0, 0, 1, 0, 32'h0000_0000);
    check("wrap_next_addr", imem_addr_o, 32'h0000_0000);

    // misaligned redirect target
    step(0, 0, 0, 0, 1, 32'hBFC0_0002);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_no_req", 32'(imem_req_o), 32'd0);
    check("mis_trap", 32'(fetch_misalign_o), 32'd1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("mis_trap_held", 32'(fetch_misalign_o), 32'd1);
    step(0, 0, 0, 0, 1, 32'hBFC0_0600);
    check("mis_trap_clr", 32'(fetch_misalign_o), 32'd0);
`else
    check("mis_aligned_addr", imem_addr_o, 32'hBFC0_0000);
    check("mis_aligned_plus4", pc_plus4_o, 32'hBFC0_0004);
    step(0, 0, 0, 0, 1, 32'hBFC0_0600);
`endif
    check("mis_after_req", 32'(imem_req_o), 32'd1);
    check("mis_after_addr", imem_addr_o, 32'hBFC0_0600);

    // reset in the middle of an outstanding read
    step(1, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    check("mid_rst_req", 32'(imem_req_o), 32'd0);
    check("mid_rst_valid", 32'(instr_valid_o), 32'd0);
    check("mid_rst_instr", instr_o, 32'h0000_0013);
    check("mid_rst_pc_o", pc_o, 32'hBFC0_0000);
    rst_n = 1'b1;
    step(0, 1, 32'h4444_4444, 0, 0, 0);
    check("late_rv_valid", 32'(instr_valid_o), 32'd0);
    check("late_rv_instr", instr_o, 32'h0000_0013);
    check("restart_addr", imem_addr_o, 32'hBFC0_0000);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h5555_5555, 0, 0, 0);
    check("restart_instr", instr_o, 32'h5555_5555);
    check("restart_pc_o", pc_o, 32'hBFC0_0000);
    step(0, 0, 0, 1, 0, 32'hBFC0_0004);
    step(0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
